number_entry_reg: RTL and testbench

- Parametrised successor to the calculator's number-register next-state logic.
- Owns the operand being typed in: digit accumulation with leading-zero suppression, sign toggle, clear, load from the ALU result, and backspace.
- Backspace uses a multi-cycle divide-by-10 behind a valid/ready handshake.
- Sits between the controller FSM (command source) and the ALU/display (consumers of number_Q).

---
 rtl/number_entry_reg.sv | 188 ++++++++++++++++++
 tb/tb_number_entry_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/number_entry_reg.sv
// Operand entry register for the calculator: digit accumulation, sign, clear,
// load from the ALU, and backspace through a serial divide-by-10.
module number_entry_reg #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_DIGITS = 9,
  parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_digit,
  input  logic [WIDTH-1:0] load_D,
  output logic [WIDTH-1:0] number_Q,
  output logic [CNT_W-1:0] digit_count,
  output logic             negative,
  output logic             overflow,
  output logic             digit_err,
  output logic             busy
);

  localparam int unsigned DIV_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_DIGIT = 3'd1;
  localparam logic [2:0] OP_BKSP  = 3'd2;
  localparam logic [2:0] OP_NEG   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;

  typedef enum logic {IDLE, DIV} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               loaded_q, loaded_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [3:0]         rem_q, rem_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;

  logic               sign_d, ovf_d, derr_d, busy_d;
  logic [CNT_W-1:0]   count_d;
  logic [WIDTH-1:0]   number_d;

  logic               accept;
  logic [WIDTH-1:0]   cur_mag;
  logic [CNT_W-1:0]   cur_cnt;
  logic [4:0]         trial;
  logic               q_bit;
  logic [3:0]         rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign in_ready = (state_q == IDLE) & ~Reset;
  assign accept   = in_valid & in_ready;

  // State and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      loaded_q    <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      number_Q    <= '0;
      digit_count <= '0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      digit_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      loaded_q    <= loaded_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_cnt_q   <= div_cnt_d;
      number_Q    <= number_d;
      digit_count <= count_d;
      negative    <= sign_d;
      overflow    <= ovf_d;
      digit_err   <= derr_d;
      busy        <= busy_d;
    end
  end

  // Next-state logic for the command decoder and the restoring divider
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    loaded_d  = loaded_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    sign_d    = negative;
    count_d   = digit_count;
    ovf_d     = overflow;
    derr_d    = digit_err;

    cur_mag = loaded_q ? '0 : mag_q;
    cur_cnt = loaded_q ? '0 : digit_count;

    // One restoring-division step: shift in the next dividend bit, subtract 10 if it fits
    trial   = {rem_q, quo_q[WIDTH-1]};
    q_bit   = (trial >= 5'd10);
    rem_nxt = q_bit ? 4'(trial - 5'd10) : 4'(trial);
    quo_nxt = {quo_q[WIDTH-2:0], q_bit};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (in_op)
            OP_DIGIT: begin
              if (in_digit > 4'd9) begin
                derr_d = 1'b1;
              end else begin
                if (loaded_q) begin
                  mag_d    = '0;
                  sign_d   = 1'b0;
                  count_d  = '0;
                  loaded_d = 1'b0;
                end
                if ((cur_mag == '0) && (in_digit == 4'd0)) begin
                  // leading zero: nothing to record
                end else if (cur_cnt == CNT_W'(MAX_DIGITS)) begin
                  ovf_d = 1'b1;
                end else begin
                  mag_d   = cur_mag * WIDTH'(10) + WIDTH'(in_digit);
                  count_d = cur_cnt + CNT_W'(1);
                end
              end
            end
            OP_BKSP: begin
              if (loaded_q) begin
                mag_d    = '0;
                sign_d   = 1'b0;
                count_d  = '0;
                loaded_d = 1'b0;
                ovf_d    = 1'b0;
                derr_d   = 1'b0;
              end else if (digit_count != '0) begin
                state_d   = DIV;
                quo_d     = mag_q;
                rem_d     = '0;
                div_cnt_d = '0;
              end
            end
            OP_NEG: begin
              if (mag_q != '0) sign_d = ~negative;
            end
            OP_CLEAR: begin
              mag_d    = '0;
              sign_d   = 1'b0;
              count_d  = '0;
              loaded_d = 1'b0;
              ovf_d    = 1'b0;
              derr_d   = 1'b0;
            end
            OP_LOAD: begin
              sign_d   = load_D[WIDTH-1];
              mag_d    = load_D[WIDTH-1] ? (WIDTH'(0) - load_D) : load_D;
              loaded_d = 1'b1;
              count_d  = CNT_W'(MAX_DIGITS);
              ovf_d    = 1'b0;
              derr_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      DIV: begin
        quo_d     = quo_nxt;
        rem_d     = rem_nxt;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == DIV_W'(WIDTH - 1)) begin
          state_d = IDLE;
          mag_d   = quo_nxt;
          count_d = digit_count - CNT_W'(1);
          if (quo_nxt == '0) sign_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    number_d = sign_d ? (WIDTH'(0) - mag_d) : mag_d;
    busy_d   = (state_d == DIV);
  end

endmodule

// File: tb/tb_number_entry_reg.sv
// Directed bench for number_entry_reg with a value-level reference model.
module tb_number_entry_reg;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic [3:0]  in_digit = 4'd0;
  logic [31:0] load_D = 32'd0;
  logic        in_ready;
  logic [31:0] number_Q;
  logic [3:0]  digit_count;
  logic        negative, overflow, digit_err, busy;

  always #5 Clock = ~Clock;

  number_entry_reg #(.WIDTH(32), .MAX_DIGITS(9)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_digit(in_digit), .load_D(load_D), .number_Q(number_Q),
    .digit_count(digit_count), .negative(negative), .overflow(overflow),
    .digit_err(digit_err), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: the operand as a plain magnitude + sign, divide latency as a countdown
  logic [31:0] m_mag = 32'd0;
  bit          m_sign = 1'b0;
  int          m_cnt = 0;
  bit          m_loaded = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_derr = 1'b0;
  int          m_div_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_mag = 32'd0; m_sign = 1'b0; m_cnt = 0; m_loaded = 1'b0; m_ovf = 1'b0; m_derr = 1'b0;
  endtask

  task automatic model_step();
    longint v;
    if (Reset) begin
      m_clear();
      m_div_left = 0;
    end else if (m_div_left > 0) begin
      m_div_left--;
      if (m_div_left == 0) begin
        m_mag = m_mag / 10;
        m_cnt--;
        if (m_mag == 0) m_sign = 1'b0;
      end
    end else if (in_valid) begin
      case (in_op)
        3'd1: begin
          if (in_digit > 9) m_derr = 1'b1;
          else begin
            if (m_loaded) begin
              m_mag = 32'd0; m_sign = 1'b0; m_cnt = 0; m_loaded = 1'b0;
            end
            if (m_mag == 0 && in_digit == 0) ;
            else if (m_cnt == 9) m_ovf = 1'b1;
            else begin
              m_mag = m_mag * 10 + 32'(in_digit);
              m_cnt++;
            end
          end
        end
        3'd2: begin
          if (m_loaded) m_clear();
          else if (m_cnt > 0) m_div_left = 32;
        end
        3'd3: if (m_mag != 0) m_sign = !m_sign;
        3'd4: m_clear();
        3'd5: begin
          v = longint'(signed'(load_D));
          m_sign = (v < 0);
          m_mag = 32'(v < 0 ? -v : v);
          m_loaded = 1'b1; m_cnt = 9; m_ovf = 1'b0; m_derr = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge Clock) model_step();

  // Compare every cycle, half a period after the active edge
  always @(negedge Clock) begin
    longint e;
    if (chk_en) begin
      e = m_sign ? -longint'(m_mag) : longint'(m_mag);
      chk("number_Q", number_Q, e[31:0]);
      chk("digit_count", 32'(digit_count), 32'(m_cnt));
      chk("negative", 32'(negative), 32'(m_sign));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("digit_err", 32'(digit_err), 32'(m_derr));
      chk("busy", 32'(busy), 32'(m_div_left > 0));
      chk("in_ready", 32'(in_ready), 32'(m_div_left == 0 && !Reset));
    end
  end

  // Called at posedge+1; returns one time unit after the accepting edge
  task automatic cmd(input logic [2:0] op, input logic [3:0] d, input logic [31:0] ld);
    int budget = 0;
    while (!in_ready && budget < 200) begin
      @(posedge Clock); #1;
      budget++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_op = op; in_digit = d; load_D = ld; in_valid = 1'b1;
      @(posedge Clock); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!in_ready && budget < 200) begin
      @(posedge Clock); #1;
      budget++;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic enter(input int n);
    int div = 1;
    while (div * 10 <= n) div *= 10;
    while (div > 0) begin
      cmd(3'd1, 4'((n / div) % 10), 32'd0);
      div /= 10;
    end
  endtask

  initial begin
    int bc;
    @(posedge Clock); #1;
    chk_en = 1'b1;
    @(posedge Clock); #1;
    chk("reset_ready", 32'(in_ready), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Leading zeros suppressed
    cmd(3'd1, 4'd0, 0); cmd(3'd1, 4'd0, 0); cmd(3'd1, 4'd4, 0); cmd(3'd1, 4'd2, 0);
    chk("lit_42", number_Q, 32'd42);
    chk("lit_42_cnt", 32'(digit_count), 32'd2);
    chk("lit_42_ovf", 32'(overflow), 32'd0);

    // Full entry then overflow
    cmd(3'd4, 0, 0);
    enter(123456789);
    cmd(3'd1, 4'd5, 0);
    chk("lit_full", number_Q, 32'd123456789);
    chk("lit_full_cnt", 32'(digit_count), 32'd9);
    chk("lit_full_ovf", 32'(overflow), 32'd1);
    cmd(3'd4, 0, 0);
    chk("lit_clr", number_Q, 32'd0);
    chk("lit_clr_ovf", 32'(overflow), 32'd0);

    // Backspace latency and value, with ignored commands during the divide
    enter(123);
    cmd(3'd3, 0, 0);
    cmd(3'd2, 0, 0);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(busy && !in_ready)) break;
      bc++;
      if (i < 4) begin in_op = 3'd1; in_digit = 4'd7; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge Clock); #1;
    end
    in_valid = 1'b0;
    chk("lit_busy_cycles", 32'(bc), 32'd32);
    chk("lit_m12", number_Q, 32'hFFFF_FFF4);
    chk("lit_m12_cnt", 32'(digit_count), 32'd2);
    cmd(3'd2, 0, 0); wait_idle();
    cmd(3'd2, 0, 0); wait_idle();
    chk("lit_bs_zero", number_Q, 32'd0);
    chk("lit_bs_neg", 32'(negative), 32'd0);
    cmd(3'd2, 0, 0);
    chk("lit_bs_empty_busy", 32'(busy), 32'd0);

    // Load, implicit clear, most negative value
    cmd(3'd5, 0, 32'hFFFF_FFF9);
    chk("lit_ld_m7", number_Q, 32'hFFFF_FFF9);
    chk("lit_ld_cnt", 32'(digit_count), 32'd9);
    cmd(3'd1, 4'd3, 0);
    chk("lit_ld_d3", number_Q, 32'd3);
    chk("lit_ld_d3_cnt", 32'(digit_count), 32'd1);
    chk("lit_ld_d3_neg", 32'(negative), 32'd0);
    cmd(3'd5, 0, 32'h8000_0000);
    chk("lit_ld_min", number_Q, 32'h8000_0000);
    chk("lit_ld_min_neg", 32'(negative), 32'd1);
    cmd(3'd3, 0, 0);
    cmd(3'd5, 0, 32'd250);
    cmd(3'd3, 0, 0);
    chk("lit_ld_neg250", number_Q, 32'hFFFF_FF06);
    cmd(3'd2, 0, 0);
    chk("lit_ld_bs_clear", number_Q, 32'd0);
    chk("lit_ld_bs_busy", 32'(busy), 32'd0);

    // Bad digit, negate on zero, reserved op
    cmd(3'd1, 4'd5, 0);
    cmd(3'd1, 4'd12, 0);
    chk("lit_derr", 32'(digit_err), 32'd1);
    chk("lit_derr_val", number_Q, 32'd5);
    cmd(3'd6, 4'd1, 0);
    cmd(3'd4, 0, 0);
    cmd(3'd3, 0, 0);
    chk("lit_neg_zero", 32'(negative), 32'd0);
    cmd(3'd5, 0, 32'd0);
    cmd(3'd1, 4'd0, 0);
    chk("lit_ld_d0", 32'(digit_count), 32'd0);

    // Reset aborts a divide
    enter(99);
    cmd(3'd2, 0, 0);
    repeat (9) begin @(posedge Clock); #1; end
    chk("lit_mid_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("lit_rst_num", number_Q, 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_cnt", 32'(digit_count), 32'd0);
    chk("lit_rst_ready", 32'(in_ready), 32'd0);
    Reset = 1'b0;
    #1;
    chk("lit_rst_ready_after", 32'(in_ready), 32'd1);
    @(posedge Clock); #1;
    enter(7);
    chk("lit_post_rst", number_Q, 32'd7);

    repeat (2) @(posedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
